// File: rtl/alu_core.sv
// Registered 16-bit execute-stage ALU: decodes OpCode/funct, computes one result,
// and presents it on res one clock after the operands are applied.
module alu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  OpCode,
    input  logic [1:0]  funct,
    input  logic [15:0] Rs,
    input  logic [15:0] Rt,
    input  logic [15:0] Pc,
    input  logic [7:0]  Imm,
    output logic [15:0] res
);

    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_SUBI  = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_ANDNI = 5'b01010;
    localparam logic [4:0] OP_XORI  = 5'b01011;
    localparam logic [4:0] OP_BNEZ  = 5'b01100;
    localparam logic [4:0] OP_BEQZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_RSHFT = 5'b11010;
    localparam logic [4:0] OP_RALU  = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    localparam logic [1:0] SH_ROL = 2'b00;
    localparam logic [1:0] SH_SLL = 2'b01;
    localparam logic [1:0] SH_ROR = 2'b10;

    logic [15:0] s_imm5;
    logic [15:0] z_imm5;
    logic [15:0] s_imm8;
    logic [15:0] addr_sum;
    logic [16:0] rr_sum;
    logic [3:0]  sh_amt;
    logic [4:0]  sh_inv;
    logic [1:0]  sh_sel;
    logic [15:0] sh_out;
    logic [15:0] rev;
    logic        lt_s;
    logic        eq;
    logic [15:0] res_d;
    logic [15:0] res_q;

    assign s_imm5   = {{11{Imm[4]}}, Imm[4:0]};
    assign z_imm5   = {11'd0, Imm[4:0]};
    assign s_imm8   = {{8{Imm[7]}}, Imm};
    assign addr_sum = Rs + s_imm5;
    // 17-bit sum gives both ADD's result and SCO's carry-out.
    assign rr_sum   = {1'b0, Rs} + {1'b0, Rt};
    assign lt_s     = $signed(Rs) < $signed(Rt);
    assign eq       = (Rs == Rt);

    // One shifter serves both forms: immediate shift opcodes' low two bits
    // use the same ROL/SLL/ROR/SRL encoding as funct.
    assign sh_amt = (OpCode == OP_RSHFT) ? Rt[3:0] : Imm[3:0];
    assign sh_sel = (OpCode == OP_RSHFT) ? funct   : OpCode[1:0];
    assign sh_inv = 5'd16 - {1'b0, sh_amt};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        sh_out = Rs >> sh_amt;
        case (sh_sel)
            SH_ROL:  sh_out = (Rs << sh_amt) | (Rs >> sh_inv);
            SH_SLL:  sh_out = Rs << sh_amt;
            SH_ROR:  sh_out = (Rs >> sh_amt) | (Rs << sh_inv);
            default: sh_out = Rs >> sh_amt;
        endcase
    end

    always_comb begin
        rev = '0;
        for (int i = 0; i < 16; i++) begin
            rev[i] = Rs[15-i];
        end
    end

    always_comb begin
        res_d = 16'h0000;
        case (OpCode)
            OP_JAL, OP_JALR:         res_d = Pc;
            OP_SUBI:                 res_d = s_imm5 - Rs;
            OP_ADDI, OP_ST, OP_LD,
            OP_STU:                  res_d = addr_sum;
            OP_ANDNI:                res_d = Rs & ~z_imm5;
            OP_XORI:                 res_d = Rs ^ z_imm5;
            OP_BNEZ:                 res_d = {15'd0, (Rs != 16'd0)};
            OP_BEQZ:                 res_d = {15'd0, (Rs == 16'd0)};
            OP_BLTZ:                 res_d = {15'd0, Rs[15]};
            OP_BGEZ:                 res_d = {15'd0, ~Rs[15]};
            OP_SLBI:                 res_d = {Rs[7:0], Imm};
            OP_ROLI, OP_SLLI,
            OP_RORI, OP_SRLI,
            OP_RSHFT:                res_d = sh_out;
            OP_LBI:                  res_d = s_imm8;
            OP_BTR:                  res_d = rev;
            OP_RALU: begin
                case (funct)
                    2'b00:   res_d = rr_sum[15:0];
                    2'b01:   res_d = Rt - Rs;
                    2'b10:   res_d = Rs ^ Rt;
                    default: res_d = Rs & ~Rt;
                endcase
            end
            OP_SEQ:                  res_d = {15'd0, eq};
            OP_SLT:                  res_d = {15'd0, lt_s};
            OP_SLE:                  res_d = {15'd0, lt_s | eq};
            OP_SCO:                  res_d = {15'd0, rr_sum[16]};
            default:                 res_d = 16'h0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= 16'h0000;
        end else begin
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus pushes hand-computed expectations,
// a clock-driven monitor pops and compares one result per cycle.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [4:0]  OpCode;
    logic [1:0]  funct;
    logic [15:0] Rs;
    logic [15:0] Rt;
    logic [15:0] Pc;
    logic [7:0]  Imm;
    logic [15:0] res;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int total = 0;
    int bad   = 0;

    alu_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .OpCode (OpCode),
        .funct  (funct),
        .Rs     (Rs),
        .Rt     (Rt),
        .Pc     (Pc),
        .Imm    (Imm),
        .res    (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one operation while clk is low; its result is due after the next rising edge.
    task automatic issue(input string name, input logic [4:0] op, input logic [1:0] fn,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] pc,
                         input logic [7:0] imm, input logic [15:0] exp);
        sb_entry_t e;
        @(negedge clk);
        OpCode = op;
        funct  = fn;
        Rs     = rs;
        Rt     = rt;
        Pc     = pc;
        Imm    = imm;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Monitor: one result per rising edge, sampled just after it.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.name, res, e.exp);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        OpCode = 5'b00000;
        funct  = 2'b00;
        Rs     = 16'h0000;
        Rt     = 16'h0000;
        Pc     = 16'h0000;
        Imm    = 8'h00;
        #2;
        check("reset_initial", res, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", res, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of operation.
        issue("pre_reset_add", 5'b11011, 2'b00, 16'h1230, 16'h0004, 16'h0, 8'h00, 16'h1234);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", res, 16'h0000);
        issue("add_after_reset", 5'b11011, 2'b00, 16'h0003, 16'h0004, 16'h0, 8'h00, 16'h0007);
        rst_n = 1'b1;
        #1;
        check("no_edge_yet", res, 16'h0000);

        // Arithmetic
        issue("subi",        5'b01000, 2'b00, 16'h0005, 16'h0000, 16'h0, 8'h1F, 16'hFFFA);
        issue("sub",         5'b11011, 2'b01, 16'h0002, 16'h000A, 16'h0, 8'h00, 16'h0008);
        issue("addi_neg",    5'b01001, 2'b11, 16'h0020, 16'h0000, 16'h0, 8'h10, 16'h0010);
        issue("xor",         5'b11011, 2'b10, 16'h0F0F, 16'h00FF, 16'h0, 8'h00, 16'h0FF0);
        issue("andn",        5'b11011, 2'b11, 16'hF0F0, 16'hFF00, 16'h0, 8'h00, 16'h00F0);
        issue("andni",       5'b01010, 2'b00, 16'hFFFF, 16'h0000, 16'h0, 8'hEF, 16'hFFF0);
        issue("xori",        5'b01011, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h1F, 16'h001F);
        issue("sco_carry",   5'b11111, 2'b00, 16'hFFFF, 16'h0001, 16'h0, 8'h00, 16'h0001);
        issue("sco_nocarry", 5'b11111, 2'b00, 16'h7FFF, 16'h0001, 16'h0, 8'h00, 16'h0000);
        issue("st_addr",     5'b10000, 2'b00, 16'h0100, 16'h0000, 16'h0, 8'h1E, 16'h00FE);
        issue("ld_addr",     5'b10001, 2'b00, 16'h0100, 16'h0000, 16'h0, 8'h05, 16'h0105);
        issue("stu_addr",    5'b10011, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h10, 16'hFFF0);

        // Shift / rotate
        issue("rol1",        5'b11010, 2'b00, 16'h8001, 16'h0001, 16'h0, 8'h00, 16'h0003);
        issue("ror1",        5'b11010, 2'b10, 16'h8001, 16'h0001, 16'h0, 8'h00, 16'hC000);
        issue("srl15",       5'b11010, 2'b11, 16'h8001, 16'h000F, 16'h0, 8'h00, 16'h0001);
        issue("sll4",        5'b11010, 2'b01, 16'h8001, 16'h0004, 16'h0, 8'h00, 16'h0010);
        issue("rol_rt_high", 5'b11010, 2'b00, 16'h8001, 16'hFFF4, 16'h0, 8'h00, 16'h0018);
        issue("slli0",       5'b10101, 2'b00, 16'h8001, 16'h0000, 16'h0, 8'h00, 16'h8001);
        issue("roli4",       5'b10100, 2'b00, 16'h8001, 16'h0000, 16'h0, 8'hF4, 16'h0018);
        issue("rori4",       5'b10110, 2'b00, 16'h8001, 16'h0000, 16'h0, 8'h04, 16'h1800);
        issue("srli4",       5'b10111, 2'b00, 16'h8001, 16'h0000, 16'h0, 8'h04, 16'h0800);

        // Compare / branch
        issue("slt_true",    5'b11101, 2'b00, 16'hFFFF, 16'h0001, 16'h0, 8'h00, 16'h0001);
        issue("slt_false",   5'b11101, 2'b00, 16'h0001, 16'hFFFF, 16'h0, 8'h00, 16'h0000);
        issue("sle_equal",   5'b11110, 2'b00, 16'h0007, 16'h0007, 16'h0, 8'h00, 16'h0001);
        issue("seq_true",    5'b11100, 2'b00, 16'h0005, 16'h0005, 16'h0, 8'h00, 16'h0001);
        issue("seq_false",   5'b11100, 2'b00, 16'h0005, 16'h0006, 16'h0, 8'h00, 16'h0000);
        issue("bltz",        5'b01110, 2'b00, 16'h8000, 16'h0000, 16'h0, 8'h00, 16'h0001);
        issue("bgez_zero",   5'b01111, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h00, 16'h0001);
        issue("bnez_zero",   5'b01100, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h00, 16'h0000);
        issue("beqz_zero",   5'b01101, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h00, 16'h0001);

        // Immediate / misc
        issue("lbi_neg",     5'b11000, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h80, 16'hFF80);
        issue("lbi_pos",     5'b11000, 2'b00, 16'h0000, 16'h0000, 16'h0, 8'h7F, 16'h007F);
        issue("slbi",        5'b10010, 2'b00, 16'h12AB, 16'h0000, 16'h0, 8'hCD, 16'hABCD);
        issue("btr_1",       5'b11001, 2'b00, 16'h0001, 16'h0000, 16'h0, 8'h00, 16'h8000);
        issue("btr_1234",    5'b11001, 2'b00, 16'h1234, 16'h0000, 16'h0, 8'h00, 16'h2C48);
        issue("jalr",        5'b00111, 2'b00, 16'h5555, 16'h0000, 16'h0102, 8'h00, 16'h0102);
        issue("jal",         5'b00110, 2'b10, 16'h0000, 16'h0000, 16'hBEEF, 8'h00, 16'hBEEF);
        issue("op_00001",    5'b00001, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 16'(sb.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 16-bit ALU for the WISC-style single-issue datapath, in the execute stage.
- Decodes the 5-bit opcode plus 2-bit funct and computes one 16-bit result.
- The result covers arithmetic, logic, shift/rotate, set-compare, branch-condition flag, immediate-load, address generation and link-PC passthrough.
- The result is registered: one cycle of latency from operand/opcode capture to `res`.

Parameters:
- None. The datapath width is fixed at 16 bits.

Ports:
- `clk`  input  1  System clock, rising-edge active.
- `rst_n`  input  1  Asynchronous, active-low reset.
- `OpCode`  input  5  Instruction opcode.
- `funct`  input  2  Function field. Used only for opcodes 11011 and 11010.
- `Rs`  input  16  First register operand.
- `Rt`  input  16  Second register operand.
- `Pc`  input  16  Link PC value (PC+2 supplied by fetch).
- `Imm`  input  8  Immediate field.
- `res`  output  16  Registered result.

Behaviour:
- Reset: while `rst_n`=0, `res` = 16'h0000 immediately, with no clock needed. Reset wins over a simultaneous clock edge.
- Timing: combinational result R is computed from the current inputs. `res` <= R on each rising `clk` edge with `rst_n`=1. Latency is 1 cycle; no stall or valid handshake.
- Immediate forms:
  - sImm5 = sign-extend `Imm[4:0]`.
  - zImm5 = zero-extend `Imm[4:0]`.
  - sImm8 = sign-extend `Imm[7:0]`.
- All arithmetic is modulo 2^16; overflow is ignored except for SCO.
- Immediate ops:
  - 01000 SUBI: sImm5 − Rs.
  - 01001 ADDI: Rs + sImm5.
  - 01010 ANDNI: Rs & ~zImm5.
  - 01011 XORI: Rs ^ zImm5.
- Immediate shifts (amount s = `Imm[3:0]`):
  - 10100 ROLI: rotate Rs left by s.
  - 10101 SLLI: Rs << s, zero fill.
  - 10110 RORI: rotate Rs right by s.
  - 10111 SRLI: Rs >> s, logical.
  - s=0 returns Rs unchanged for all four.
- Address generation: 10000 ST, 10001 LD and 10011 STU all return Rs + sImm5.
- 11001 BTR: bit reverse, R[i] = Rs[15−i].
- 11011 register ALU, selected by `funct`:
  - 00 ADD: Rs + Rt.
  - 01 SUB: Rt − Rs.
  - 10 XOR: Rs ^ Rt.
  - 11 ANDN: Rs & ~Rt.
- 11010 register shift, selected by `funct`, amount = `Rt[3:0]`; upper bits of Rt are ignored:
  - 00 ROL.
  - 01 SLL.
  - 10 ROR.
  - 11 SRL.
- Set-compare ops return 16'd1 if true, else 16'd0. Comparisons are two's-complement signed.
  - 11100 SEQ: Rs == Rt.
  - 11101 SLT: Rs < Rt.
  - 11110 SLE: Rs <= Rt.
  - 11111 SCO: carry-out (bit 16) of unsigned Rs + Rt.
- Branch-condition ops return 16'd1 if the branch is taken, else 16'd0:
  - 01100 BNEZ: Rs != 0.
  - 01101 BEQZ: Rs == 0.
  - 01110 BLTZ: Rs[15] = 1.
  - 01111 BGEZ: Rs[15] = 0.
- Immediate loads:
  - 11000 LBI: sImm8.
  - 10010 SLBI: {Rs[7:0], Imm}.
- Link ops: 00110 JAL and 00111 JALR return `Pc`.
- All other opcodes (00000–00101) return 16'h0000.
- `funct` is a don't-care for every opcode except 11011 and 11010.

Test Plan:
- Reset: drive `rst_n`=0 mid-operation with `res`=16'h1234 → `res`=0 without a clock edge. Release reset, apply ADD Rs=3, Rt=4 → `res`=7 exactly one edge later.
- Arithmetic:
  - SUBI Imm=8'h1F (sImm5=−1), Rs=5 → 16'hFFFA.
  - SUB Rs=2, Rt=10 → 8.
  - ADDI Imm=8'h10, Rs=16'h0020 → 16'h0010.
  - SCO Rs=16'hFFFF, Rt=1 → 1.
- Shift/rotate with Rs=16'h8001:
  - ROL by 1 → 16'h0003.
  - ROR by 1 → 16'hC000.
  - SRL by 15 → 1.
  - SLLI by 0 → 16'h8001.
  - ROL with Rt=16'hFFF4 uses amount 4 → 16'h0018.
- Compare/branch:
  - SLT Rs=16'hFFFF, Rt=1 → 1.
  - SLE Rs=Rt=7 → 1.
  - BLTZ Rs=16'h8000 → 1.
  - BGEZ Rs=0 → 1.
  - BNEZ Rs=0 → 0.
- Immediate/misc:
  - LBI Imm=8'h80 → 16'hFF80.
  - SLBI Rs=16'h12AB, Imm=8'hCD → 16'hABCD.
  - BTR Rs=16'h0001 → 16'h8000.
  - JALR Pc=16'h0102 → 16'h0102.
  - Opcode 00001 → 0.
